// File: rtl/core_sequencer.sv
// Program sequencer: fetches buffered instructions by core PC and drives the run/done handshake.
// Optional watchdog on the WAIT state is enabled by defining SEQ_WATCHDOG_EN.
module core_sequencer #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       pc,
  input  logic              done,
  output logic              run,
  output logic [31:0]       command,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [15:0]       retired
);

  localparam logic [31:0] Ecall = 32'h0000_0073;

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StHalt} state_e;

  if (DEPTH != (32'd1 << ADDR_W) || TIMEOUT == 0) begin : g_param_check
    $error("core_sequencer: DEPTH must equal 2**ADDR_W and TIMEOUT must be nonzero");
  end

  state_e      r_state, w_state_d;
  logic [31:0] r_buf [DEPTH];
  logic        r_stop, r_run, r_busy, r_halted, r_error;
  logic [31:0] r_cmd;
  logic [15:0] r_retired;

  logic        w_misaligned, w_beyond, w_stop_req, w_wd_expire, w_issue, w_next_busy;
  logic [31:0] w_word;

  assign w_misaligned = |pc[1:0];
  assign w_beyond     = |pc[31:ADDR_W+2];
  assign w_word       = r_buf[pc[ADDR_W+1:2]];
  assign w_stop_req   = r_stop | stop;

`ifdef SEQ_WATCHDOG_EN
  logic [31:0] r_wd;

  // Held at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || r_state != StWait) r_wd <= '0;
    else                            r_wd <= r_wd + 32'd1;
  end

  assign w_wd_expire = (r_state == StWait) && (r_wd == 32'(TIMEOUT - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_issue   = 1'b0;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StFetch;
      StFetch: begin
        if (w_stop_req)                    w_state_d = StIdle;
        else if (w_misaligned || w_beyond) w_state_d = StHalt;
        else begin
          w_state_d = StIssue;
          w_issue   = (w_word != Ecall);
        end
      end
      // Without a pending issue we are here because of ECALL or a stop request.
      StIssue: begin
        if (r_run)       w_state_d = StWait;
        else if (r_stop) w_state_d = StIdle;
        else             w_state_d = StHalt;
      end
      StWait: begin
        if (done)             w_state_d = w_stop_req ? StIdle : StFetch;
        else if (w_wd_expire) w_state_d = StHalt;
      end
      StHalt:  if (start) w_state_d = StFetch;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_next_busy = (w_state_d == StFetch) || (w_state_d == StIssue) || (w_state_d == StWait);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_stop    <= 1'b0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_error   <= 1'b0;
      r_cmd     <= '0;
      r_retired <= '0;
    end else begin
      r_state  <= w_state_d;
      r_busy   <= w_next_busy;
      r_halted <= (w_state_d == StHalt);
      r_run    <= w_issue;

      if (!w_next_busy)     r_stop <= 1'b0;
      else if (r_busy && stop) r_stop <= 1'b1;

      if (w_issue) r_cmd <= w_word;

      if (r_state == StHalt && start) begin
        r_error   <= 1'b0;
        r_retired <= '0;
      end else begin
        if (r_state == StFetch && !w_stop_req && w_misaligned) r_error <= 1'b1;
        if (w_wd_expire && !done)                              r_error <= 1'b1;
        if (r_state == StWait && done && r_retired != 16'hFFFF)
          r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Buffer survives reset; writes only land while the sequencer is parked.
  always_ff @(posedge clk) begin
    if (load_we && (r_state == StIdle || r_state == StHalt)) r_buf[load_addr] <= load_data;
  end

  assign run     = r_run;
  assign command = r_cmd;
  assign busy    = r_busy;
  assign halted  = r_halted;
  assign error   = r_error;
  assign retired = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer (DEPTH=64, TIMEOUT=32).
module tb_core_sequencer;

  logic        clk, reset, load_we, start, stop, done;
  logic [5:0]  load_addr;
  logic [31:0] load_data, pc;
  logic        run, busy, halted, error;
  logic [31:0] command;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int run_cnt  = 0;

  core_sequencer #(.DEPTH(64), .ADDR_W(6), .TIMEOUT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .stop      (stop),
    .pc        (pc),
    .done      (done),
    .run       (run),
    .command   (command),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (run === 1'b1) run_cnt <= run_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; pc = '0; done = 1'b0;
    ticks(2);
    reset = 1'b0;
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_command", command, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    load(6'd0, 32'h0100_0093);
    load(6'd1, 32'h0000_0073);
    load(6'd3, 32'h0000_0073);

    // ADDI then ECALL
    pc = 32'd0; start = 1'b1; tick(); start = 1'b0;
    chk("t1_fetch_busy", {31'd0, busy}, 32'd1);
    chk("t1_fetch_run", {31'd0, run}, 32'd0);
    tick();
    chk("t1_issue_run", {31'd0, run}, 32'd1);
    chk("t1_issue_cmd", command, 32'h0100_0093);
    tick();
    chk("t1_wait_run", {31'd0, run}, 32'd0);
    chk("t1_wait_cmd_hold", command, 32'h0100_0093);
    done = 1'b1; pc = 32'd4; tick(); done = 1'b0;
    chk("t1_retired", {16'd0, retired}, 32'd1);
    tick();
    chk("t1_ecall_norun", {31'd0, run}, 32'd0);
    tick();
    chk("t1_halted", {31'd0, halted}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_error", {31'd0, error}, 32'd0);
    chk("t1_retired_end", {16'd0, retired}, 32'd1);
    chk("t1_run_cnt", run_cnt, 32'd1);

    // PC past end of buffer: normal halt
    pc = 32'd256; start = 1'b1; tick(); start = 1'b0;
    chk("t2_retired_clr", {16'd0, retired}, 32'd0);
    tick();
    chk("t2_halted", {31'd0, halted}, 32'd1);
    chk("t2_error", {31'd0, error}, 32'd0);
    chk("t2_run_cnt", run_cnt, 32'd1);

    // Misaligned PC: error halt, then restart clears it
    pc = 32'd6; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t3_halted", {31'd0, halted}, 32'd1);
    chk("t3_error", {31'd0, error}, 32'd1);
    pc = 32'd0; start = 1'b1; tick(); start = 1'b0;
    chk("t3_error_clr", {31'd0, error}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t3_issue_run", {31'd0, run}, 32'd1);
    chk("t3_issue_cmd", command, 32'h0100_0093);
    tick();

    // Stop in WAIT, done three cycles later
    stop = 1'b1; tick(); stop = 1'b0;
    ticks(2);
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    done = 1'b1; pc = 32'd4; tick(); done = 1'b0;
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_halted", {31'd0, halted}, 32'd0);
    chk("t4_retired", {16'd0, retired}, 32'd1);
    ticks(3);
    chk("t4_run_cnt", run_cnt, 32'd2);
    chk("t4_stay_idle", {31'd0, busy}, 32'd0);

    // Load and start in the same IDLE cycle
    load_we = 1'b1; load_addr = 6'd2; load_data = 32'h0020_0113;
    pc = 32'd8; start = 1'b1; tick();
    load_we = 1'b0; start = 1'b0;
    tick();
    chk("t6_issue_run", {31'd0, run}, 32'd1);
    chk("t6_issue_cmd", command, 32'h0020_0113);
    tick();
    done = 1'b1; pc = 32'd12; tick(); done = 1'b0;
    chk("t6_retired", {16'd0, retired}, 32'd2);
    ticks(2);
    chk("t6_halted", {31'd0, halted}, 32'd1);

    // Back-to-back issue, dropped busy write, reset in WAIT
    pc = 32'd0; start = 1'b1; tick(); start = 1'b0;
    chk("t5_retired_clr", {16'd0, retired}, 32'd0);
    tick();
    chk("t5_issue1", {31'd0, run}, 32'd1);
    tick();
    done = 1'b1; pc = 32'd0; tick(); done = 1'b0;
    chk("t5_retired", {16'd0, retired}, 32'd1);
    tick();
    chk("t5_issue2_run", {31'd0, run}, 32'd1);
    chk("t5_issue2_cmd", command, 32'h0100_0093);
    tick();
    load(6'd0, 32'hDEAD_BEEF);
    reset = 1'b1; done = 1'b1; tick(); reset = 1'b0; done = 1'b0;
    chk("t5_rst_run", {31'd0, run}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_retired", {16'd0, retired}, 32'd0);
    chk("t5_rst_cmd", command, 32'd0);
    tick();
    pc = 32'd0; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t5_reissue_run", {31'd0, run}, 32'd1);
    chk("t5_reissue_cmd", command, 32'h0100_0093);
    tick();

    // Done withheld in WAIT
    ticks(31);
    chk("t7_wait32_busy", {31'd0, busy}, 32'd1);
    chk("t7_wait32_halted", {31'd0, halted}, 32'd0);
    tick();
`ifdef SEQ_WATCHDOG_EN
    chk("t7_wd_halted", {31'd0, halted}, 32'd1);
    chk("t7_wd_error", {31'd0, error}, 32'd1);
`else
    ticks(70);
    chk("t7_nowd_busy", {31'd0, busy}, 32'd1);
    chk("t7_nowd_halted", {31'd0, halted}, 32'd0);
    chk("t7_nowd_error", {31'd0, error}, 32'd0);
`endif
    chk("t7_run_cnt", run_cnt, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
